fxp_seq_multiplier: RTL and testbench

// - Parametrised signed fixed-point iterative (shift-add) multiplier for the MHA datapath.
// - Q(W-FRAC).FRAC x Q(W-FRAC).FRAC -> same format, with rounding and saturation.
// - Valid/ready handshake on both sides. One operation in flight.
// - Shared by the score/softmax/projection stages where area matters more than throughput.

---
 rtl/mha_fxp_pkg.sv | 23 ++
 rtl/fxp_round_sat.sv | 48 ++++
 rtl/fxp_seq_multiplier.sv | 101 ++++++++++
 tb/tb_fxp_seq_multiplier.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mha_fxp_pkg.sv
// Shared types and constants for the MHA fixed-point arithmetic blocks.
package mha_fxp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fxp_state_e;

    localparam int MHA_W    = 16;
    localparam int MHA_FRAC = 8;

    // Saturation bounds as 64-bit patterns; callers keep the low w bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Turns an unsigned 2W-bit product magnitude plus sign into a rounded,
// saturated signed Q-format result (round half away from zero).
module fxp_round_sat
    import mha_fxp_pkg::*;
#(
    parameter int W    = MHA_W,
    parameter int FRAC = MHA_FRAC
) (
    input  logic [2*W-1:0] mag,
    input  logic           neg,
    output logic [W-1:0]   result,
    output logic           ovf
);

    localparam int RW = 2 * W + 1;
    localparam logic [RW-1:0] HALF    = RW'(1) << (FRAC - 1);
    localparam logic [RW-1:0] POS_LIM = (RW'(1) << (W - 1)) - RW'(1);
    localparam logic [RW-1:0] NEG_LIM = RW'(1) << (W - 1);
    localparam logic [63:0]   SAT_MAX_64 = sat_max(W);
    localparam logic [63:0]   SAT_MIN_64 = sat_min(W);

    logic [RW-1:0] sum;
    logic [RW-1:0] r;

    always_comb begin
        sum    = {1'b0, mag} + HALF;
        r      = sum >> FRAC;
        result = '0;
        ovf    = 1'b0;
        if (!neg) begin
            if (r > POS_LIM) begin
                result = SAT_MAX_64[W-1:0];
                ovf    = 1'b1;
            end else begin
                result = r[W-1:0];
            end
        end else begin
            // r == 2^(W-1) negates to exactly the most negative code.
            if (r > NEG_LIM) begin
                result = SAT_MIN_64[W-1:0];
                ovf    = 1'b1;
            end else begin
                result = -r[W-1:0];
            end
        end
    end

endmodule

// File: rtl/fxp_seq_multiplier.sv
// Signed fixed-point shift-add multiplier, one multiplier bit per cycle,
// one operation in flight, valid/ready on both sides.
module fxp_seq_multiplier
    import mha_fxp_pkg::*;
#(
    parameter int W     = MHA_W,
    parameter int FRAC  = MHA_FRAC,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic         I_CLK,
    input  logic         I_RST,
    input  logic         I_VLD,
    output logic         O_RDY,
    input  logic [W-1:0] I_M1,
    input  logic [W-1:0] I_M2,
    output logic         O_VLD,
    input  logic         I_RDY,
    output logic [W-1:0] O_PRODUCT,
    output logic         O_OVF,
    output logic [1:0]   O_STATE
);

    // Handshake: a transfer happens at a rising edge where valid and ready
    // are both high; valid/data hold until then, ready never waits on valid.

    fxp_state_e       state, state_next;
    logic [W-1:0]     m1_mag, m2_mag;
    logic             sign;
    logic [2*W-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     rs_result;
    logic             rs_ovf;

    assign O_STATE = state;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        O_RDY      = 1'b0;
        O_VLD      = 1'b0;
        unique case (state)
            IDLE: begin
                O_RDY = 1'b1;
                if (I_VLD) state_next = CALC;
            end
            CALC: if (cnt == CNT_W'(W - 1)) state_next = NORM;
            NORM: state_next = DONE;
            DONE: begin
                O_VLD = 1'b1;
                if (I_RDY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Magnitudes are held unsigned so |-2^(W-1)| fits in W bits.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            m1_mag    <= '0;
            m2_mag    <= '0;
            sign      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            O_PRODUCT <= '0;
            O_OVF     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (I_VLD) begin
                    m1_mag <= I_M1[W-1] ? -I_M1 : I_M1;
                    m2_mag <= I_M2[W-1] ? -I_M2 : I_M2;
                    sign   <= I_M1[W-1] ^ I_M2[W-1];
                    acc    <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    // m2_mag shifts right so bit 0 is multiplier bit cnt.
                    if (m2_mag[0]) acc <= acc + ({{W{1'b0}}, m1_mag} << cnt);
                    m2_mag <= m2_mag >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                NORM: begin
                    O_PRODUCT <= rs_result;
                    O_OVF     <= rs_ovf;
                end
                default: ;
            endcase
        end
    end

    fxp_round_sat #(.W(W), .FRAC(FRAC)) u_round_sat (
        .mag    (acc),
        .neg    (sign),
        .result (rs_result),
        .ovf    (rs_ovf)
    );

endmodule

// File: tb/tb_fxp_seq_multiplier.sv
// Directed bench for fxp_seq_multiplier (W=16, FRAC=8) with an arithmetic
// reference model and per-handshake scoreboard.
module tb_fxp_seq_multiplier;
    import mha_fxp_pkg::*;

    localparam int W = 16;
    localparam int N = 12;

    logic         I_CLK, I_RST, I_VLD, O_RDY, O_VLD, I_RDY, O_OVF;
    logic [W-1:0] I_M1, I_M2, O_PRODUCT;
    logic [1:0]   O_STATE;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    fxp_seq_multiplier #(.W(W), .FRAC(8)) dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_VLD(I_VLD), .O_RDY(O_RDY),
        .I_M1(I_M1), .I_M2(I_M2), .O_VLD(O_VLD), .I_RDY(I_RDY),
        .O_PRODUCT(O_PRODUCT), .O_OVF(O_OVF), .O_STATE(O_STATE)
    );

    // clock / reset
    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer product, rounded on magnitude, then clamped.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p, mag, r;
        bit neg;
        p   = longint'($signed(a)) * longint'($signed(b));
        neg = (p < 0);
        mag = neg ? -p : p;
        r   = (mag + 128) / 256;
        if (!neg) begin
            if (r > 32767) return {1'b1, 16'h7FFF};
            return {1'b0, 16'(r)};
        end
        if (r > 32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(-r)};
    endfunction

    // scoreboard: one compare per output handshake, plus protocol check
    always @(negedge I_CLK) begin
        if (!I_RST) begin
            if (O_RDY && O_VLD) check("rdy_vld_exclusive", 32'(O_RDY & O_VLD), 32'd0);
            if (O_VLD && I_RDY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("sb_product", 32'(O_PRODUCT), 32'(e[W-1:0]));
                    check("sb_ovf", 32'(O_OVF), 32'(e[W]));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!O_RDY && n < 50) begin @(posedge I_CLK); #1; n++; end
        if (!O_RDY) check("wait_o_rdy_timeout", 32'(O_RDY), 32'd1);
    endtask

    // driver: issue one pair, check latency and literal result, then
    // hold off downstream for `hold` cycles while offering ignored traffic
    task automatic run_op(input logic [W-1:0] m1, input logic [W-1:0] m2,
                          input logic [W-1:0] exp_p, input logic exp_o, input int hold);
        int lat;
        wait_ready();
        I_M1  = m1;
        I_M2  = m2;
        I_VLD = 1'b1;
        exp_q.push_back(model(m1, m2));
        @(posedge I_CLK); #1;
        I_VLD = 1'b0;
        I_M1  = W'($urandom);
        I_M2  = W'($urandom);
        check("busy_o_rdy", 32'(O_RDY), 32'd0);
        lat = 0;
        while (!O_VLD && lat < 40) begin @(posedge I_CLK); #1; lat++; end
        check("latency", 32'(lat), 32'd17);
        check("lit_product", 32'(O_PRODUCT), 32'(exp_p));
        check("lit_ovf", 32'(O_OVF), 32'(exp_o));
        for (int i = 0; i < hold; i++) begin
            I_VLD = 1'b1;
            I_M1  = W'($urandom);
            I_M2  = W'($urandom);
            @(posedge I_CLK); #1;
            check("hold_o_vld", 32'(O_VLD), 32'd1);
            check("hold_o_rdy", 32'(O_RDY), 32'd0);
            check("hold_product", 32'(O_PRODUCT), 32'(exp_p));
            check("hold_ovf", 32'(O_OVF), 32'(exp_o));
        end
        I_VLD = 1'b0;
        I_RDY = 1'b1;
        @(posedge I_CLK); #1;
        I_RDY = 1'b0;
        check("post_hs_o_vld", 32'(O_VLD), 32'd0);
        check("post_hs_o_rdy", 32'(O_RDY), 32'd1);
    endtask

    logic [W-1:0] v_m1[N]  = '{16'h0180, 16'hFE80, 16'hFE80, 16'h0000, 16'h8000, 16'h7FFF,
                               16'h8000, 16'h0001, 16'hFFFF, 16'h0001, 16'h0140, 16'hC000};
    logic [W-1:0] v_m2[N]  = '{16'h0200, 16'h0200, 16'hFE00, 16'h8000, 16'h8000, 16'h8000,
                               16'h0100, 16'h0080, 16'h0080, 16'h007F, 16'hFF80, 16'h4000};
    logic [W-1:0] v_exp[N] = '{16'h0300, 16'hFD00, 16'h0300, 16'h0000, 16'h7FFF, 16'h8000,
                               16'h8000, 16'h0001, 16'hFFFF, 16'h0000, 16'hFF60, 16'h8000};
    logic         v_ovf[N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int           v_hold[N] = '{0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 5, 2};

    initial begin
        I_RST = 1'b1;
        I_VLD = 1'b0;
        I_RDY = 1'b0;
        I_M1  = '0;
        I_M2  = '0;
        repeat (3) @(posedge I_CLK);
        #1;
        check("rst_o_rdy", 32'(O_RDY), 32'd1);
        check("rst_o_vld", 32'(O_VLD), 32'd0);
        check("rst_product", 32'(O_PRODUCT), 32'd0);
        check("rst_ovf", 32'(O_OVF), 32'd0);
        check("rst_state", 32'(O_STATE), 32'(IDLE));
        I_RST = 1'b0;
        @(posedge I_CLK); #1;

        for (int i = 0; i < N; i++)
            run_op(v_m1[i], v_m2[i], v_exp[i], v_ovf[i], v_hold[i]);

        // abort in CALC cycle 7; O_PRODUCT still holds 0x8000 from the last op
        wait_ready();
        I_M1  = 16'h0300;
        I_M2  = 16'h0200;
        I_VLD = 1'b1;
        @(posedge I_CLK); #1;
        I_VLD = 1'b0;
        repeat (7) @(posedge I_CLK);
        #1;
        I_RST = 1'b1;
        #1;
        check("abort_o_rdy", 32'(O_RDY), 32'd1);
        check("abort_o_vld", 32'(O_VLD), 32'd0);
        check("abort_product", 32'(O_PRODUCT), 32'd0);
        check("abort_ovf", 32'(O_OVF), 32'd0);
        check("abort_state", 32'(O_STATE), 32'(IDLE));
        @(posedge I_CLK); #1;
        I_RST = 1'b0;
        @(posedge I_CLK); #1;
        run_op(16'h0100, 16'h0100, 16'h0100, 1'b0, 0);
        run_op(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 0);

        repeat (3) @(posedge I_CLK);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
